snake_display_decoder: RTL and testbench

SNAKE_DISPLAY_DECODER -- requirements
Module: snake_display_decoder

---
 rtl/snake_display_decoder_pkg.sv | 40 ++++
 rtl/snake_display_decoder_if.sv | 33 +++
 rtl/snake_display_decoder_frame_match.sv | 35 +++
 rtl/snake_display_decoder.sv | 91 +++++++++
 tb/tb_snake_display_decoder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/snake_display_decoder_pkg.sv
// ============================================================================
// Module      : snake_pkg
// Description : Shared types, constants and the ring-to-segment map for the
//               two-digit rotating "snake" display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

  typedef logic [3:0] phase_t;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    CANDIDATE = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam logic [11:0] SNAKE_INIT   = 12'hE00;
  localparam int          SNAKE_PHASES = 12;

  // Returns {disp_1, disp_2}; segments shared by two ring cells are OR-ed.
  function automatic logic [13:0] ring_to_seg(input logic [11:0] b);
    return {b[5], 1'b0, 1'b0, b[11], b[0], b[6], b[7] | b[1],
            b[4], b[3], b[9], b[10], 1'b0, 1'b0, b[2] | b[8]};
  endfunction

  function automatic logic [11:0] ring_of_phase(input int p);
    logic [11:0] r;
    r = (SNAKE_INIT >> p) | (SNAKE_INIT << (SNAKE_PHASES - p));
    return r;
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    return (p == 4'(SNAKE_PHASES - 1)) ? 4'd0 : p + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_display_decoder_if.sv
// ============================================================================
// Module      : snake_display_decoder_if
// Description : Frame input and tracker status bundle of the snake decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snake_display_decoder_if;
  import snake_pkg::*;

  logic       sample;
  logic [6:0] disp_1;
  logic [6:0] disp_2;
  phase_t     phase;
  logic       frame_ok;
  logic       locked;
  logic       step_err;
  logic [7:0] err_count;
  logic [7:0] lap_count;

  modport master (
    output sample, disp_1, disp_2,
    input  phase, frame_ok, locked, step_err, err_count, lap_count
  );

  modport slave (
    input  sample, disp_1, disp_2,
    output phase, frame_ok, locked, step_err, err_count, lap_count
  );

endinterface

`default_nettype wire

// File: rtl/snake_display_decoder_frame_match.sv
// ============================================================================
// Module      : snake_frame_match
// Description : Combinational matcher of a segment frame against the twelve
//               legal snake encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_frame_match
  import snake_pkg::*;
(
  input  logic [6:0] disp_1,
  input  logic [6:0] disp_2,
  output logic       valid,
  output phase_t     p
);

  logic [SNAKE_PHASES-1:0] w_hit;

  for (genvar i = 0; i < SNAKE_PHASES; i++) begin : g_phase
    localparam logic [11:0] c_ring = ring_of_phase(i);
    assign w_hit[i] = ({disp_1, disp_2} == ring_to_seg(c_ring));
  end

  always_comb begin
    valid = $onehot(w_hit);
    p     = '0;
    for (int i = 0; i < SNAKE_PHASES; i++) begin
      if (w_hit[i]) p = 4'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/snake_display_decoder.sv
// ============================================================================
// Module      : snake_display_decoder
// Description : Decodes the snake animation frames and tracks phase lock,
//               sequence errors and completed laps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_display_decoder
  import snake_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  snake_display_decoder_if.slave  bus
);

  logic   w_valid;
  phase_t w_p;

  state_t     r_state, w_next_state;
  phase_t     r_phase;
  logic       r_frame_ok, r_locked, r_step_err;
  logic [7:0] r_err_count, r_lap_count;
  logic       w_err, w_lap, w_succ;

  snake_frame_match u_match (
    .disp_1 (bus.disp_1),
    .disp_2 (bus.disp_2),
    .valid  (w_valid),
    .p      (w_p)
  );

  // r_phase doubles as the stored phase: it loads exactly when a frame is valid.
  assign w_succ = w_valid && (w_p == next_phase(r_phase));

  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_lap        = 1'b0;
    if (bus.sample) begin
      case (r_state)
        UNLOCKED:  if (w_valid) w_next_state = CANDIDATE;
        CANDIDATE: begin
          if (!w_valid)    w_next_state = UNLOCKED;
          else if (w_succ) w_next_state = LOCKED;
        end
        LOCKED: begin
          if (w_succ) begin
            w_lap = (r_phase == 4'(SNAKE_PHASES - 1));
          end else begin
            w_err        = 1'b1;
            w_next_state = w_valid ? CANDIDATE : UNLOCKED;
          end
        end
        default:   w_next_state = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= UNLOCKED;
      r_phase     <= '0;
      r_frame_ok  <= 1'b0;
      r_locked    <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_count <= '0;
      r_lap_count <= '0;
    end else if (bus.sample) begin
      r_state    <= w_next_state;
      r_frame_ok <= w_valid;
      r_locked   <= (w_next_state == LOCKED);
      r_step_err <= w_err;
      if (w_valid) r_phase <= w_p;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_lap) r_lap_count <= r_lap_count + 8'd1;
    end else begin
      r_step_err <= 1'b0;
    end
  end

  assign bus.phase     = r_phase;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.locked    = r_locked;
  assign bus.step_err  = r_step_err;
  assign bus.err_count = r_err_count;
  assign bus.lap_count = r_lap_count;

endmodule

`default_nettype wire

// File: tb/tb_snake_display_decoder.sv
// ============================================================================
// Module      : tb_snake_display_decoder
// Description : Directed self-checking bench for snake_display_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_display_decoder;
  import snake_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  // Hand-derived legal encodings, index = phase.
  logic [6:0] seg1 [12] = '{7'h08, 7'h00, 7'h01, 7'h03, 7'h43, 7'h42,
                            7'h40, 7'h00, 7'h01, 7'h05, 7'h0D, 7'h0C};
  logic [6:0] seg2 [12] = '{7'h18, 7'h19, 7'h11, 7'h01, 7'h00, 7'h40,
                            7'h60, 7'h61, 7'h21, 7'h01, 7'h00, 7'h08};

  snake_display_decoder_if bus ();

  snake_display_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(input int p_or_raw, input logic raw, input logic [6:0] d1, input logic [6:0] d2);
    @(negedge clock);
    bus.sample = 1'b1;
    bus.disp_1 = raw ? d1 : seg1[p_or_raw];
    bus.disp_2 = raw ? d2 : seg2[p_or_raw];
    @(posedge clock);
    #1;
    bus.sample = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"}, 32'(bus.phase), 32'd0);
    chk({tag, "_frame_ok"}, 32'(bus.frame_ok), 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_step_err"}, 32'(bus.step_err), 32'd0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_lap_count"}, 32'(bus.lap_count), 32'd0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'(UNLOCKED));
  endtask

  initial begin
    int cur;
    bus.sample = 1'b0;
    bus.disp_1 = '0;
    bus.disp_2 = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_zero("rst");
    @(negedge clock);
    reset = 1'b0;

    // Acquire lock on p=0 then p=1
    frame(0, 1'b0, 7'h0, 7'h0);
    chk("acq0_frame_ok", 32'(bus.frame_ok), 32'd1);
    chk("acq0_phase", 32'(bus.phase), 32'd0);
    chk("acq0_locked", 32'(bus.locked), 32'd0);
    frame(1, 1'b0, 7'h0, 7'h0);
    chk("acq1_locked", 32'(bus.locked), 32'd1);
    chk("acq1_phase", 32'(bus.phase), 32'd1);
    chk("acq1_lap", 32'(bus.lap_count), 32'd0);

    // Twelve more steps, wrapping once
    for (int i = 2; i < 14; i++) begin
      frame(i % 12, 1'b0, 7'h0, 7'h0);
      chk("run_step_err", 32'(bus.step_err), 32'd0);
      chk("run_phase", 32'(bus.phase), 32'(i % 12));
      chk("run_locked", 32'(bus.locked), 32'd1);
      if (i == 12) chk("run_lap_wrap", 32'(bus.lap_count), 32'd1);
    end
    chk("run_lap_end", 32'(bus.lap_count), 32'd1);
    chk("run_err_end", 32'(bus.err_count), 32'd0);

    // All-zero frame while locked
    frame(0, 1'b1, 7'h00, 7'h00);
    chk("blank_frame_ok", 32'(bus.frame_ok), 32'd0);
    chk("blank_step_err", 32'(bus.step_err), 32'd1);
    chk("blank_err_count", 32'(bus.err_count), 32'd1);
    chk("blank_locked", 32'(bus.locked), 32'd0);
    chk("blank_state", 32'(dut.r_state), 32'(UNLOCKED));
    chk("blank_phase_hold", 32'(bus.phase), 32'd1);
    @(posedge clock);
    #1;
    chk("blank_pulse_end", 32'(bus.step_err), 32'd0);

    // Skip from p=3 to p=5, then recover on p=6
    frame(2, 1'b0, 7'h0, 7'h0);
    chk("relock2_locked", 32'(bus.locked), 32'd0);
    frame(3, 1'b0, 7'h0, 7'h0);
    chk("relock3_locked", 32'(bus.locked), 32'd1);
    frame(5, 1'b0, 7'h0, 7'h0);
    chk("skip_step_err", 32'(bus.step_err), 32'd1);
    chk("skip_err_count", 32'(bus.err_count), 32'd2);
    chk("skip_state", 32'(dut.r_state), 32'(CANDIDATE));
    chk("skip_phase", 32'(bus.phase), 32'd5);
    chk("skip_locked", 32'(bus.locked), 32'd0);
    frame(6, 1'b0, 7'h0, 7'h0);
    chk("skip_relock", 32'(bus.locked), 32'd1);
    chk("skip_relock_err", 32'(bus.step_err), 32'd0);

    // Advance to p=4 through another wrap
    for (int i = 7; i < 17; i++) frame(i % 12, 1'b0, 7'h0, 7'h0);
    chk("run2_lap", 32'(bus.lap_count), 32'd2);
    chk("run2_phase", 32'(bus.phase), 32'd4);

    // Repeated p=4, then ten idle cycles with junk on the displays
    frame(4, 1'b0, 7'h0, 7'h0);
    chk("rep_step_err", 32'(bus.step_err), 32'd1);
    chk("rep_err_count", 32'(bus.err_count), 32'd3);
    chk("rep_state", 32'(dut.r_state), 32'(CANDIDATE));
    chk("rep_phase", 32'(bus.phase), 32'd4);
    chk("rep_locked", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.disp_1 = 7'($urandom);
      bus.disp_2 = 7'($urandom);
      @(posedge clock);
      #1;
      chk("idle_step_err", 32'(bus.step_err), 32'd0);
      chk("idle_phase", 32'(bus.phase), 32'd4);
      chk("idle_frame_ok", 32'(bus.frame_ok), 32'd1);
      chk("idle_locked", 32'(bus.locked), 32'd0);
      chk("idle_err_count", 32'(bus.err_count), 32'd3);
      chk("idle_lap_count", 32'(bus.lap_count), 32'd2);
    end
    frame(5, 1'b0, 7'h0, 7'h0);
    chk("rep_relock", 32'(bus.locked), 32'd1);

    // 300 repeat errors, each followed by a relocking step
    cur = 5;
    for (int k = 0; k < 300; k++) begin
      frame(cur, 1'b0, 7'h0, 7'h0);
      if (k == 299) chk("sat_pulse", 32'(bus.step_err), 32'd1);
      cur = (cur + 1) % 12;
      frame(cur, 1'b0, 7'h0, 7'h0);
    end
    chk("sat_err_count", 32'(bus.err_count), 32'd255);
    chk("sat_locked", 32'(bus.locked), 32'd1);
    chk("sat_lap_count", 32'(bus.lap_count), 32'd2);
    chk("sat_phase", 32'(bus.phase), 32'd5);

    // Reset in the middle of a sampled frame
    @(negedge clock);
    bus.sample = 1'b1;
    bus.disp_1 = seg1[6];
    bus.disp_2 = seg2[6];
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clock);
    bus.sample = 1'b0;
    reset = 1'b0;

    frame(7, 1'b0, 7'h0, 7'h0);
    chk("post_rst_frame_ok", 32'(bus.frame_ok), 32'd1);
    chk("post_rst_locked", 32'(bus.locked), 32'd0);
    chk("post_rst_state", 32'(dut.r_state), 32'(CANDIDATE));
    frame(8, 1'b0, 7'h0, 7'h0);
    chk("post_rst_relock", 32'(bus.locked), 32'd1);
    chk("post_rst_phase", 32'(bus.phase), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
